// File: rtl/ariane_pkg.sv
// Subset of ariane_pkg carrying the LSU request type and operation encoding
// consumed by the store issue queue.
package ariane_pkg;

  localparam int unsigned VLEN          = 64;
  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [7:0] {
    ADD, SUB, LD, LW, LH, LB, SD, SW, SH, SB,
    AMO_LRW, AMO_SCW, AMO_SWAPW, AMO_ADDW, AMO_LRD, AMO_SCD, AMO_SWAPD, AMO_ADDD
  } fu_op;

  typedef struct packed {
    logic [VLEN-1:0]          vaddr;
    logic [XLEN-1:0]          data;
    logic [(XLEN/8)-1:0]      be;
    fu_op                     operation;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } lsu_ctrl_t;

endpackage

// File: rtl/st_issue_queue.sv
// Store/AMO issue queue between issue and the store unit: circular buffer
// with a zero-latency bypass when empty and a sticky overflow flag.
module st_issue_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      valid_i,
  input  lsu_ctrl_t lsu_ctrl_i,
  output logic      ready_o,
  output logic      valid_o,
  output lsu_ctrl_t lsu_ctrl_o,
  input  logic      pop_i,
  output logic      empty_o,
  output logic      overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  lsu_ctrl_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]   r_cnt;
  logic             r_overflow;

  logic w_empty, w_full, w_bypass, w_push, w_pop, w_ovf;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_FULL);
  // Bypassed request is consumed straight from the input and never stored.
  assign w_bypass = w_empty && valid_i && pop_i;
  assign w_push   = valid_i && !w_full && !flush_i && !w_bypass;
  assign w_pop    = pop_i && !w_empty && !flush_i;
  // A same-cycle pop does not make room: fullness comes from registered state.
  assign w_ovf    = valid_i && w_full && !flush_i;

  assign ready_o    = !w_full;
  assign empty_o    = w_empty;
  assign overflow_o = r_overflow;
  assign valid_o    = !flush_i && !rst_i && (!w_empty || valid_i);
  assign lsu_ctrl_o = w_empty ? lsu_ctrl_i : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= lsu_ctrl_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
      if (w_ovf) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_st_issue_queue.sv
// Directed bench for st_issue_queue (DEPTH=2) with an in-order scoreboard of
// expected requests.
module tb_st_issue_queue;
  import ariane_pkg::*;

  logic      clk = 1'b0;
  logic      rst_i, flush_i, valid_i, pop_i;
  lsu_ctrl_t lsu_ctrl_i, lsu_ctrl_o;
  logic      ready_o, valid_o, empty_o, overflow_o;

  int checks = 0;
  int failures = 0;
  lsu_ctrl_t sb[$];
  lsu_ctrl_t r;

  st_issue_queue #(.DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .lsu_ctrl_i(lsu_ctrl_i), .ready_o(ready_o), .valid_o(valid_o),
    .lsu_ctrl_o(lsu_ctrl_o), .pop_i(pop_i), .empty_o(empty_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic lsu_ctrl_t mk(input int id);
    lsu_ctrl_t t;
    t.vaddr     = {$urandom, $urandom};
    t.data      = {$urandom, $urandom};
    t.be        = 8'($urandom);
    t.operation = (id % 2 == 0) ? SD : AMO_SWAPW;
    t.trans_id  = 3'(id);
    return t;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input lsu_ctrl_t obs, input lsu_ctrl_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the offered request against the oldest expected entry and retire it.
  task automatic pop_chk(input string tag);
    lsu_ctrl_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=offer expected=scoreboard_entry", tag);
    end else begin
      e = sb.pop_front();
      chk1({tag, "_vld"}, valid_o, 1'b1);
      chks(tag, lsu_ctrl_o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1; pop_i = 1'b0; lsu_ctrl_i = mk(7);
    #1;
    chk1("rst_valid_o", valid_o, 1'b0);
    cyc();
    rst_i = 1'b0; valid_i = 1'b0;
    #1;
    chk1("rst_empty", empty_o, 1'b1);
    chk1("rst_ready", ready_o, 1'b1);
    chk1("rst_ovf", overflow_o, 1'b0);
    chk1("rst_valid_idle", valid_o, 1'b0);

    // Bypass: empty, valid and pop in the same cycle
    r = mk(3); valid_i = 1'b1; pop_i = 1'b1; lsu_ctrl_i = r;
    #1;
    chk1("byp_valid", valid_o, 1'b1);
    chks("byp_data", lsu_ctrl_o, r);
    cyc();
    valid_i = 1'b0; pop_i = 1'b0;
    #1;
    chk1("byp_empty", empty_o, 1'b1);
    chk1("byp_valid_after", valid_o, 1'b0);

    // Ignored pop while empty
    pop_i = 1'b1;
    cyc();
    pop_i = 1'b0;

    // Fill and drain
    r = mk(1); valid_i = 1'b1; lsu_ctrl_i = r; sb.push_back(r);
    #1;
    chks("fill_bypass_view", lsu_ctrl_o, r);
    cyc();
    r = mk(2); lsu_ctrl_i = r; sb.push_back(r);
    #1;
    chks("fill_head_stable", lsu_ctrl_o, sb[0]);
    cyc();
    valid_i = 1'b0;
    #1;
    chk1("full_ready", ready_o, 1'b0);
    chk1("full_empty", empty_o, 1'b0);
    pop_i = 1'b1;
    #1;
    pop_chk("drain1");
    cyc();
    pop_chk("drain2");
    cyc();
    pop_i = 1'b0;
    #1;
    chk1("drain_ready", ready_o, 1'b1);
    chk1("drain_empty", empty_o, 1'b1);

    // Overflow: push at full with a same-cycle pop is dropped
    for (int k = 4; k <= 5; k++) begin
      r = mk(k); valid_i = 1'b1; lsu_ctrl_i = r; sb.push_back(r);
      cyc();
    end
    lsu_ctrl_i = mk(6); pop_i = 1'b1;
    #1;
    pop_chk("ovf_pop");
    cyc();
    valid_i = 1'b0; pop_i = 1'b0;
    #1;
    chk1("ovf_flag", overflow_o, 1'b1);
    chk1("ovf_ready_cnt1", ready_o, 1'b1);
    chk1("ovf_not_empty", empty_o, 1'b0);
    pop_i = 1'b1;
    #1;
    pop_chk("ovf_survivor");
    cyc();
    pop_i = 1'b0;
    #1;
    chk1("ovf_sticky", overflow_o, 1'b1);
    chk1("ovf_drained", empty_o, 1'b1);

    // Wrap: ids 0..5 through a one-deep occupancy
    r = mk(0); valid_i = 1'b1; lsu_ctrl_i = r; sb.push_back(r);
    cyc();
    pop_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      r = mk(k); lsu_ctrl_i = r;
      #1;
      pop_chk("wrap");
      sb.push_back(r);
      cyc();
      chk1("wrap_cnt1", empty_o, 1'b0);
    end
    valid_i = 1'b0;
    #1;
    pop_chk("wrap_last");
    cyc();
    pop_i = 1'b0;
    #1;
    chk1("wrap_empty", empty_o, 1'b1);

    // Flush with two held and a request presented
    for (int k = 1; k <= 2; k++) begin
      valid_i = 1'b1; lsu_ctrl_i = mk(k);
      cyc();
    end
    flush_i = 1'b1; lsu_ctrl_i = mk(3);
    #1;
    chk1("flush_valid", valid_o, 1'b0);
    cyc();
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    chk1("flush_empty", empty_o, 1'b1);
    chk1("flush_ovf_clr", overflow_o, 1'b0);
    chk1("flush_ready", ready_o, 1'b1);
    chk1("flush_valid_after", valid_o, 1'b0);

    // Reset mid-stream with one held
    valid_i = 1'b1; lsu_ctrl_i = mk(7);
    cyc();
    valid_i = 1'b0; rst_i = 1'b1;
    #1;
    chk1("mrst_valid", valid_o, 1'b0);
    cyc();
    rst_i = 1'b0;
    #1;
    chk1("mrst_empty", empty_o, 1'b1);
    chk1("mrst_ready", ready_o, 1'b1);
    chk1("mrst_valid_after", valid_o, 1'b0);

    // Post-reset traffic uses clean pointers
    r = mk(2); valid_i = 1'b1; lsu_ctrl_i = r; sb.push_back(r);
    cyc();
    valid_i = 1'b0; pop_i = 1'b1;
    #1;
    pop_chk("post_rst");
    cyc();
    pop_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
